cond_check: RTL and testbench
=============================

COND_CHECK -- requirements
Module: cond_check

Interface
REQ-001 Parameter: WIDTH, default 16, operand width in bits (signed two's complement); legal range 2..64.
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset; asynchronous, active-low.
REQ-004 in_valid  input  1  operands and cond are valid this cycle.
REQ-005 in1  input  WIDTH  signed first operand.
REQ-006 in2  input  WIDTH  signed second operand.
REQ-007 cond  input  2  condition code: 00 EQ, 01 NE, 10 signed GT, 11 signed LT.
REQ-008 flag  output  4  registered compare flags {N,Z,C,V} at bits [3:0].
REQ-009 out  output  1  registered condition result: 1 true, 0 false.
REQ-010 out_valid  output  1  flag/out updated from an accepted input this cycle.

Function
REQ-011 Compare SHALL compute in1 - in2 as in1 + ~in2 + 1 at WIDTH+1 bits.
REQ-012 N SHALL equal result bit WIDTH-1.
REQ-013 Z SHALL be 1 iff the WIDTH-bit result is zero.
REQ-014 C SHALL be the carry out of bit WIDTH-1 (1 iff in1 >= in2 unsigned).
REQ-015 V SHALL be 1 iff operand signs differ and result sign differs from in1 sign.
REQ-016 cond SHALL evaluate: EQ = Z; NE = !Z; GT = !Z & (N == V); LT = (N != V).
REQ-017 On a rising clk with in_valid=1, flag and out SHALL load the values for that cycle's in1/in2/cond; out_valid SHALL be 1 the following cycle (latency 1).
REQ-018 With in_valid=0, flag and out SHALL hold their last values and out_valid SHALL be 0.
REQ-019 Back-to-back in_valid SHALL give one result per cycle, with no bubbles and no stall.
REQ-020 Boundaries: in1 = in2 SHALL give Z=1 and C=1; most-negative minus +1 SHALL give V=1; operands at min/max SHALL never cause X or truncation errors.
REQ-021 No input combinational path SHALL reach any output.

Reset
REQ-022 While rst_n=0, flag SHALL be 4'b0000, out 0, and out_valid 0, independent of clk.
REQ-023 A deassertion of rst_n SHALL take effect at the next rising clk; an input presented in the same cycle SHALL NOT be captured.
REQ-024 A reset asserted mid-stream SHALL discard the in-flight result.

Configuration
REQ-025 Macro COND_CHECK_UNSIGNED_EN: when defined, an extra input port uns (1 bit, after cond) SHALL be present. With uns=1, GT SHALL be C & !Z and LT SHALL be !C. EQ, NE and flag SHALL be unchanged.
REQ-026 When COND_CHECK_UNSIGNED_EN is undefined, the uns port SHALL be absent and GT/LT SHALL be signed only.

Verification
REQ-027 in1=10, in2=15, cond=00, in_valid=1 -> next cycle flag=1000, out=0, out_valid=1.
REQ-028 in1=25, in2=-30, cond=10 -> flag=0000, out=1.
REQ-029 in1=25, in2=25, cond=11 -> flag=0110, out=0; then cond=01 with the same operands -> out=0.
REQ-030 in1=32767, in2=-1, cond=10 -> flag=1001, out=1 (overflow case).
REQ-031 Assert rst_n=0 between clock edges while out=1 -> flag, out and out_valid go to 0 immediately; with in_valid=0 after release, outputs stay 0.
REQ-032 With COND_CHECK_UNSIGNED_EN defined: in1=25, in2=-30, cond=10, uns=1 -> out=0; with uns=0 -> out=1.

Source files
------------

// File: rtl/cond_check.sv
// Registered compare-and-condition unit: produces {N,Z,C,V} flags and a condition result.
// Optional COND_CHECK_UNSIGNED_EN adds a uns input for unsigned GT/LT.
module cond_check #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [1:0]       cond,
`ifdef COND_CHECK_UNSIGNED_EN
  input  logic             uns,
`endif
  output logic [3:0]       flag,
  output logic             out,
  output logic             out_valid
);

  localparam logic [1:0] CC_EQ = 2'b00;
  localparam logic [1:0] CC_NE = 2'b01;
  localparam logic [1:0] CC_GT = 2'b10;
  localparam logic [1:0] CC_LT = 2'b11;

  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] res;
  logic             n_flag;
  logic             z_flag;
  logic             c_flag;
  logic             v_flag;
  logic             gt_s;
  logic             lt_s;
  logic             gt_d;
  logic             lt_d;
  logic             res_d;
  logic [3:0]       flag_d;

  logic [3:0]       flag_q;
  logic             out_q;
  logic             vld_q;
  logic             arm_q;
  logic             cap;

  // Subtract as in1 + ~in2 + 1 so bit WIDTH is the true carry out.
  always_comb begin
    sum    = {1'b0, in1} + {1'b0, ~in2} + {{WIDTH{1'b0}}, 1'b1};
    res    = sum[WIDTH-1:0];
    n_flag = res[WIDTH-1];
    z_flag = ~|res;
    c_flag = sum[WIDTH];
    v_flag = (in1[WIDTH-1] ^ in2[WIDTH-1])
           & (res[WIDTH-1] ^ in1[WIDTH-1]);
    flag_d = {n_flag, z_flag, c_flag, v_flag};
  end

  always_comb begin
    gt_s = ~z_flag & (n_flag == v_flag);
    lt_s = (n_flag != v_flag);
    gt_d = gt_s;
    lt_d = lt_s;
`ifdef COND_CHECK_UNSIGNED_EN
    if (uns) begin
      gt_d = c_flag & ~z_flag;
      lt_d = ~c_flag;
    end
`endif
  end

  always_comb begin
    res_d = 1'b0;
    unique case (cond)
      CC_EQ: res_d = z_flag;
      CC_NE: res_d = ~z_flag;
      CC_GT: res_d = gt_d;
      CC_LT: res_d = lt_d;
      default: res_d = 1'b0;
    endcase
  end

  // arm_q blocks capture on the first edge after reset release.
  assign cap = in_valid & arm_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      arm_q  <= 1'b0;
      flag_q <= 4'b0000;
      out_q  <= 1'b0;
      vld_q  <= 1'b0;
    end else begin
      arm_q <= 1'b1;
      vld_q <= cap;
      if (cap) begin
        flag_q <= flag_d;
        out_q  <= res_d;
      end
    end
  end

  assign flag      = flag_q;
  assign out       = out_q;
  assign out_valid = vld_q;

endmodule

// File: tb/tb_cond_check.sv
// Directed table-driven bench for cond_check (WIDTH=16).
// Covers flags, conditions, hold, back-to-back, reset corners.
module tb_cond_check;

  localparam int W = 16;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic [W-1:0] in1;
  logic [W-1:0] in2;
  logic [1:0]   cond;
`ifdef COND_CHECK_UNSIGNED_EN
  logic         uns;
`endif
  logic [3:0]   flag;
  logic         out;
  logic         out_valid;

  int checks;
  int errors;

  cond_check #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in1      (in1),
    .in2      (in2),
    .cond     (cond),
`ifdef COND_CHECK_UNSIGNED_EN
    .uns      (uns),
`endif
    .flag     (flag),
    .out      (out),
    .out_valid(out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [1:0]   cc;
    logic [3:0]   eflag;
    logic         eout;
  } vec_t;

  vec_t tbl [14];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string name, input logic [3:0] ef,
                         input logic eo, input logic ev);
    chk({name, ".flag"}, {28'd0, flag}, {28'd0, ef});
    chk({name, ".out"}, {31'd0, out}, {31'd0, eo});
    chk({name, ".valid"}, {31'd0, out_valid}, {31'd0, ev});
  endtask

  task automatic drive(input logic v, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [1:0] cc);
    in_valid = v;
    in1      = a;
    in2      = b;
    cond     = cc;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    // {in1, in2, cond, flag NZCV, out}
    tbl[0]  = '{16'd10,     16'd15,     2'b00, 4'b1000, 1'b0};
    tbl[1]  = '{16'd25,     -16'sd30,   2'b10, 4'b0000, 1'b1};
    tbl[2]  = '{16'd25,     16'd25,     2'b11, 4'b0110, 1'b0};
    tbl[3]  = '{16'd25,     16'd25,     2'b01, 4'b0110, 1'b0};
    tbl[4]  = '{16'd32767,  16'hFFFF,   2'b10, 4'b1001, 1'b1};
    tbl[5]  = '{16'h8000,   16'd1,      2'b11, 4'b0011, 1'b1};
    tbl[6]  = '{16'd25,     16'd25,     2'b00, 4'b0110, 1'b1};
    tbl[7]  = '{16'd10,     16'd15,     2'b11, 4'b1000, 1'b1};
    tbl[8]  = '{16'd10,     16'd15,     2'b01, 4'b1000, 1'b1};
    tbl[9]  = '{16'h8000,   16'h7FFF,   2'b10, 4'b0011, 1'b0};
    tbl[10] = '{16'd0,      16'd0,      2'b10, 4'b0110, 1'b0};
    tbl[11] = '{16'hFFFF,   16'd0,      2'b11, 4'b1010, 1'b1};
    tbl[12] = '{16'd0,      16'hFFFF,   2'b10, 4'b0000, 1'b1};
    tbl[13] = '{16'h7FFF,   16'h8000,   2'b11, 4'b1001, 1'b0};

    rst_n = 1'b0;
    drive(1'b1, 16'd10, 16'd15, 2'b00);
`ifdef COND_CHECK_UNSIGNED_EN
    uns = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1 chk_all("reset", 4'b0000, 1'b0, 1'b0);

    // release mid-cycle with valid input: first edge must not capture
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, 16'd25, 16'd25, 2'b00);
    @(posedge clk);
    #1 chk_all("rel_nocap", 4'b0000, 1'b0, 1'b0);

    // back-to-back, one vector per cycle
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      drive(1'b1, tbl[i].a, tbl[i].b, tbl[i].cc);
      @(posedge clk);
      #1 chk_all($sformatf("vec%0d", i), tbl[i].eflag, tbl[i].eout, 1'b1);
    end

    // hold with in_valid low and changing inputs
    @(negedge clk);
    drive(1'b0, 16'd1, 16'd2, 2'b00);
    @(posedge clk);
    #1 chk_all("hold1", 4'b1001, 1'b0, 1'b0);
    @(negedge clk);
    drive(1'b0, 16'd5, 16'd5, 2'b00);
    @(posedge clk);
    #1 chk_all("hold2", 4'b1001, 1'b0, 1'b0);

`ifdef COND_CHECK_UNSIGNED_EN
    @(negedge clk);
    drive(1'b1, 16'd25, -16'sd30, 2'b10);
    uns = 1'b1;
    @(posedge clk);
    #1 chk_all("uns_gt1", 4'b0000, 1'b0, 1'b1);
    @(negedge clk);
    uns = 1'b0;
    @(posedge clk);
    #1 chk_all("uns_gt0", 4'b0000, 1'b1, 1'b1);
    @(negedge clk);
    uns = 1'b1;
    cond = 2'b11;
    @(posedge clk);
    #1 chk_all("uns_lt1", 4'b0000, 1'b1, 1'b1);
    uns = 1'b0;
`endif

    // mid-stream async reset while out=1
    @(negedge clk);
    drive(1'b1, 16'd32767, 16'hFFFF, 2'b10);
    @(posedge clk);
    #1 chk_all("pre_rst", 4'b1001, 1'b1, 1'b1);
    #2 rst_n = 1'b0;
    #1 chk_all("async_rst", 4'b0000, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b0, 16'd32767, 16'hFFFF, 2'b10);
    repeat (2) @(posedge clk);
    #1 chk_all("post_rst", 4'b0000, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
